sqrt_iter_seq: RTL and testbench

//  Parametrised, multi-cycle fixed-point integer square root. Replaces the unrolled

---
 rtl/sqrt_iter_seq.sv | 137 +++++++++++++
 tb/tb_sqrt_iter_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_iter_seq.sv
// Iterative fixed-point integer square root.
// One result bit is produced per cycle by the restoring digit recurrence.
// The recurrence uses only shifts, a subtract and a sign test.
// The block computes result = floor(sqrt(x << 2*FRAC_W)).
// The remainder and an exact flag come out with the result.
// Valid/ready handshakes are provided on both the input and output sides.
module sqrt_iter_seq #(
  parameter  int IN_W   = 16,
  parameter  int FRAC_W = 8,
  localparam int RES_W  = IN_W / 2 + FRAC_W,
  localparam int RAD_W  = IN_W + 2 * FRAC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic [RES_W:0]   rem,
  output logic             exact,
  output logic             busy
);

  localparam int CNT_W = $clog2(RES_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(RES_W - 1);

  // The recurrence pairs radicand bits, so an odd width has no meaning.
  if (((IN_W % 2) != 0) || (IN_W < 2)) begin : g_param_check
    $error("sqrt_iter_seq: IN_W must be even and >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [RAD_W-1:0] rad;        // radicand, consumed two bits at a time from the MSB end
  logic [RES_W-1:0] root;       // partial root built so far
  logic [RES_W-1:0] prem;       // partial remainder; always <= 2*root between iterations
  logic [CNT_W-1:0] cnt;

  logic [1:0]              pair;
  logic [RES_W+1:0]        acc;
  logic signed [RES_W+2:0] trial;
  logic                    take;
  logic [RES_W+1:0]        prem_next;
  logic [RES_W-1:0]        root_next;

  // Trial subtraction: (prem<<2 | pair) - (root<<2 | 1).
  // One extra sign bit makes a negative result unambiguous.
  function automatic logic signed [RES_W+2:0] trial_sub(
    input logic [RES_W+1:0] a,
    input logic [RES_W-1:0] r
  );
    logic signed [RES_W+2:0] lhs;
    logic signed [RES_W+2:0] rhs;
    lhs = signed'({1'b0, a});
    rhs = signed'({1'b0, r, 2'b01});
    return lhs - rhs;
  endfunction

  // One recurrence step from the current partial root and remainder.
  always_comb begin
    pair      = rad[RAD_W-1 -: 2];
    acc       = {prem, pair};
    trial     = trial_sub(acc, root);
    take      = ~trial[RES_W+2];
    prem_next = take ? trial[RES_W+1:0] : acc;
    root_next = (root << 1) | RES_W'(take);
  end

  // Control FSM with the iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      rem       <= '0;
      exact     <= 1'b0;
      rad       <= '0;
      root      <= '0;
      prem      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            rad      <= RAD_W'(x) << (2 * FRAC_W);
            root     <= '0;
            prem     <= '0;
            cnt      <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          rad  <= rad << 2;
          root <= root_next;
          // Intermediate remainders fit RES_W bits because the root is not yet full width.
          prem <= prem_next[RES_W-1:0];
          if (cnt == LAST_ITER) begin
            state     <= DONE;
            result    <= root_next;
            rem       <= prem_next[RES_W:0];
            exact     <= (prem_next == '0);
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // Results hold after the handshake; only the control flags change.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter_seq.sv
// Directed testbench for sqrt_iter_seq.
// The default instance (IN_W=16, FRAC_W=8) runs a table of hand-computed vectors.
// It then runs the backpressure and mid-calculation reset sequences.
// A second, small instance (IN_W=8, FRAC_W=0) checks a narrow configuration.
module tb_sqrt_iter_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance
  logic        in_valid, in_ready, out_valid, out_ready, exact, busy;
  logic [15:0] x;
  logic [15:0] result;
  logic [16:0] rem;

  // Narrow instance
  logic        in_valid8, in_ready8, out_valid8, out_ready8, exact8, busy8;
  logic [7:0]  x8;
  logic [3:0]  result8;
  logic [4:0]  rem8;

  sqrt_iter_seq #(.IN_W(16), .FRAC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .rem(rem),
    .exact(exact), .busy(busy)
  );

  sqrt_iter_seq #(.IN_W(8), .FRAC_W(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .x(x8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8), .rem(rem8),
    .exact(exact8), .busy(busy8)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] res;
    logic [16:0] rem;
    logic        exact;
  } vec_t;

  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Offer one radicand, measure the latency and collect the outputs.
  // Then complete the output handshake.
  task automatic run_op(input logic [15:0] xv, output logic [15:0] r, output logic [16:0] rm,
                        output logic ex, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    x        = xv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("in_ready_after_accept", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r  = result;
    rm = rem;
    ex = exact;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_handshake", out_valid, 0);
    check("in_ready_after_handshake", in_ready, 1);
  endtask

  // Same flow for the narrow instance.
  task automatic run_op8(input logic [7:0] xv, output logic [3:0] r, output logic [4:0] rm,
                         output int lat);
    @(negedge clk);
    in_valid8 = 1'b1;
    x8        = xv;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r  = result8;
    rm = rem8;
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic [16:0] rm;
    logic        ex;
    int          lat;
    logic [3:0]  r8;
    logic [4:0]  rm8;
    logic        seen_valid;

    vecs[0]  = '{16'd16,    16'h0400, 17'd0,      1'b1};
    vecs[1]  = '{16'd2,     16'h016A, 17'd28,     1'b0};
    vecs[2]  = '{16'hFFFF,  16'hFFFF, 17'd65535,  1'b0};
    vecs[3]  = '{16'd0,     16'h0000, 17'd0,      1'b1};
    vecs[4]  = '{16'd1,     16'h0100, 17'd0,      1'b1};
    vecs[5]  = '{16'd9,     16'h0300, 17'd0,      1'b1};
    vecs[6]  = '{16'd3,     16'h01BB, 17'd359,    1'b0};
    vecs[7]  = '{16'd100,   16'h0A00, 17'd0,      1'b1};
    vecs[8]  = '{16'h4000,  16'h8000, 17'd0,      1'b1};
    vecs[9]  = '{16'd5,     16'h023C, 17'd496,    1'b0};
    vecs[10] = '{16'hFFFE,  16'hFFFE, 17'd131068, 1'b0};
    vecs[11] = '{16'h8000,  16'hB504, 17'd88048,  1'b0};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    x          = '0;
    in_valid8  = 1'b0;
    out_ready8 = 1'b0;
    x8         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_result", result, 0);
    check("reset_rem", rem, 0);
    check("reset_exact", exact, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].x, r, rm, ex, lat);
      check($sformatf("result[x=0x%0h]", vecs[i].x), r, vecs[i].res);
      check($sformatf("rem[x=0x%0h]", vecs[i].x), rm, vecs[i].rem);
      check($sformatf("exact[x=0x%0h]", vecs[i].x), ex, vecs[i].exact);
      check($sformatf("latency[x=0x%0h]", vecs[i].x), lat, 16);
      check($sformatf("hold_after_handshake[x=0x%0h]", vecs[i].x), result, vecs[i].res);
    end

    // Backpressure: the result stays stable and no new radicand is taken while DONE.
    @(negedge clk);
    in_valid = 1'b1;
    x        = 16'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", lat, 16);
    @(negedge clk);
    in_valid = 1'b1;
    x        = 16'd100;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid_held", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_result_stable", result, 16'h01BB);
      check("bp_rem_stable", rem, 17'd359);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_busy", busy, 0);
    check("bp_release_result_hold", result, 16'h01BB);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_reaccept_busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_second_latency", lat, 16);
    check("bp_second_result", result, 16'h0A00);
    check("bp_second_exact", exact, 1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during iteration 7 aborts the run and clears the outputs.
    @(negedge clk);
    in_valid = 1'b1;
    x        = 16'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_rem", rem, 0);
    check("abort_exact", exact, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort_no_out_valid", seen_valid, 0);
    run_op(16'd9, r, rm, ex, lat);
    check("post_abort_result", r, 16'h0300);
    check("post_abort_exact", ex, 1);
    check("post_abort_latency", lat, 16);

    // Narrow configuration: 4-bit root, 4-cycle latency.
    run_op8(8'd200, r8, rm8, lat);
    check("n8_result_200", r8, 4'd14);
    check("n8_rem_200", rm8, 5'd4);
    check("n8_latency_200", lat, 4);
    run_op8(8'd255, r8, rm8, lat);
    check("n8_result_255", r8, 4'd15);
    check("n8_rem_255", rm8, 5'd30);
    run_op8(8'd0, r8, rm8, lat);
    check("n8_result_0", r8, 4'd0);
    check("n8_rem_0", rm8, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
